// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED animation controller with step-aligned mode changes
module led_sequencer #(
  parameter int NUM_LED  = 5,
  parameter int PRESCALE = 2080000,
  parameter int CNT_W    = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode_req,
  input  logic               mode_valid,
  output logic               mode_ready,
  input  logic               pause,
  output logic [NUM_LED-1:0] led,
  output logic               busy,
  output logic               step_tick
);
  typedef enum logic [1:0] {OFF, CHASE, BOUNCE, FILL} mode_t;
  localparam int PW = $clog2(NUM_LED + 1);
  localparam logic [NUM_LED-1:0] ONE = NUM_LED'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);
  localparam logic [PW-1:0] TOP = PW'(NUM_LED - 1);
  localparam logic [PW-1:0] FULL = PW'(NUM_LED);
  mode_t mode, mode_n, pend_mode, pend_mode_n, new_mode;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [PW-1:0] pos, pos_n, fill, fill_n, chase_pos, bounce_pos;
  logic dir, dir_n, bounce_dir, pend_v, pend_v_n;
  logic [NUM_LED-1:0] led_n;
  logic tick, accept, apply_req, apply_pend, apply, store;
  always_comb begin
    tick = mode != OFF && !pause && cnt == LAST;
    accept = mode_valid && mode_ready;
    apply_req = accept && (mode == OFF || tick);
    apply_pend = pend_v && tick;
    apply = apply_req || apply_pend;
    store = accept && !apply_req;
    new_mode = apply_req ? mode_t'(mode_req) : pend_mode;
    chase_pos = pos == TOP ? '0 : pos + PW'(1);
    bounce_dir = (!dir && pos == TOP) ? 1'b1 : (dir && pos == '0) ? 1'b0 : dir;
    bounce_pos = bounce_dir ? pos - PW'(1) : pos + PW'(1);
    mode_n = mode;
    cnt_n = (mode == OFF) ? '0 : pause ? cnt : tick ? '0 : cnt + CNT_W'(1);
    pos_n = pos;
    dir_n = dir;
    fill_n = fill;
    led_n = led;
    pend_v_n = (pend_v && !apply_pend) || store;
    pend_mode_n = store ? mode_t'(mode_req) : pend_mode;
    if (apply) begin
      mode_n = new_mode;
      cnt_n = '0;
      pos_n = '0;
      dir_n = 1'b0;
      fill_n = '0;
      led_n = (new_mode == CHASE || new_mode == BOUNCE) ? ONE : '0;
    end else if (tick) begin
      pos_n = mode == CHASE ? chase_pos : mode == BOUNCE ? bounce_pos : pos;
      dir_n = mode == BOUNCE ? bounce_dir : dir;
      fill_n = mode == FILL ? (fill == FULL ? '0 : fill + PW'(1)) : fill;
      led_n = mode == FILL ? ~({NUM_LED{1'b1}} << fill_n) : ONE << pos_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= OFF;
      pend_mode <= OFF;
      pend_v <= 1'b0;
      cnt <= '0;
      pos <= '0;
      dir <= 1'b0;
      fill <= '0;
      led <= '0;
      mode_ready <= 1'b1;
      busy <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      mode <= mode_n;
      pend_mode <= pend_mode_n;
      pend_v <= pend_v_n;
      cnt <= cnt_n;
      pos <= pos_n;
      dir <= dir_n;
      fill <= fill_n;
      led <= led_n;
      mode_ready <= !pend_v_n;
      busy <= mode_n != OFF;
      step_tick <= tick;
    end
  end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Controller that sequences the board's 5-LED bank through selectable animation patterns.
- Runs directly on the internal oscillator clock and contains its own step prescaler, replacing the free-running divider-plus-pattern arrangement.
- Mode changes use a valid/ready handshake and take effect only on step boundaries, so patterns never glitch mid-step.
- Sits between top-level control (buttons/UART/fixed strap) and the LED pin assignments.

Parameters:
- NUM_LED, 5, number of LEDs driven; legal 2..16.
- PRESCALE, 2080000, clk cycles per animation step (1 step/s at 2.08 MHz); legal >= 2.
- CNT_W, 22, prescaler counter width; must satisfy 2^CNT_W >= PRESCALE.

Ports:
- clk  input  1  internal oscillator clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode_req  input  2  requested mode: 0 OFF, 1 CHASE, 2 BOUNCE, 3 FILL.
- mode_valid  input  1  request present; held until accepted.
- mode_ready  output  1  block can accept a request.
- pause  input  1  freezes the prescaler and pattern while high.
- led  output  NUM_LED  active-high LED drive; bit 0 is the first LED of the chain.
- busy  output  1  high when the current mode is not OFF.
- step_tick  output  1  one-cycle pulse on each animation step.

Behaviour:
- Reset (synchronous, wins over all inputs): led=0, mode=OFF, pos=0, dir=up, fill_cnt=0, pending empty, prescaler=0, mode_ready=1, busy=0, step_tick=0.
- All outputs are registered.
- Prescaler:
  - While mode!=OFF and pause=0, cnt increments each cycle.
  - At cnt==PRESCALE-1, cnt wraps to 0 and step_tick pulses on that same edge.
  - pause=1 holds cnt and suppresses ticks.
  - In OFF mode cnt is held at 0.
- Handshake:
  - Acceptance occurs when mode_valid && mode_ready at a clock edge.
  - mode_ready = !pending_valid.
  - In OFF mode, an accepted request is applied on the accepting edge. It does not become pending, and mode_ready stays 1.
  - In a running mode, an accepted request is stored as pending and mode_ready drops.
  - The pending request is applied on the next step_tick edge; mode_ready returns to 1 after that edge.
  - Acceptance on the same edge as a tick in a running mode applies immediately; that tick's pattern advance is discarded.
  - A pending request waits indefinitely while pause=1.
- Apply (mode load):
  - cnt=0, pos=0, dir=up, fill_cnt=0.
  - led is loaded with the initial pattern: OFF 0; CHASE 1<<0; BOUNCE 1<<0; FILL 0.
  - Re-requesting the current mode restarts its pattern.
- Step (a tick with no apply):
  - CHASE: pos = (pos==NUM_LED-1) ? 0 : pos+1; led = 1<<pos.
  - BOUNCE: if dir=up and pos==NUM_LED-1, set dir=down and pos=NUM_LED-2; if dir=down and pos==0, set dir=up and pos=1; otherwise pos moves one step in dir. led = 1<<pos. Sequence for 5 LEDs: 0,1,2,3,4,3,2,1,0,1… Ends are not repeated.
  - FILL: fill_cnt = (fill_cnt==NUM_LED) ? 0 : fill_cnt+1; led = (1<<fill_cnt)-1. Period is NUM_LED+1 steps.
- busy reflects the mode register, so it changes on the apply edge.
- rst asserted mid-pattern or with a request pending clears everything to reset values on that edge; a pending request is lost.

Test Plan (PRESCALE=4, NUM_LED=5):
- Reset -> led=00000, mode_ready=1, busy=0, no step_tick for 20 cycles.
- In OFF, request CHASE at edge k -> led=00001, busy=1 after edge k; step_tick at k+4, k+8, …; led 00010, 00100, 01000, 10000, then 00001 on the 5th tick.
- BOUNCE for 10 ticks -> led bit index sequence after each tick: 1,2,3,4,3,2,1,0,1,2.
- FILL for 7 ticks -> led 00001, 00011, 00111, 01111, 11111, 00000, 00001.
- CHASE running at pos=2, request FILL mid-step -> mode_ready=0 until the next tick; at the tick led=00000 (not 01000); mode_ready=1 on the following cycle; a second request is held off while pending.
- pause=1 for 10 cycles mid-CHASE with a pending OFF -> no step_tick, led frozen; after release, the tick arrives after the remaining prescaler count and led=00000, busy=0. A separate run asserting rst with a request pending -> all reset values next cycle.
